// File: rtl/ex_div.sv
// ex_div: iterative 32-bit radix-2 restoring divider for the EX stage.
// It implements DIV/DIVU/REM/REMU and takes 32 CALC cycles per op. It also
// requests an EX stall while an op is in flight and holds the result until
// the stage after EX advances.
//
// Optional build macro: EX_DIV_FAST_SPECIAL_EN
//   When defined, divide-by-zero and signed overflow are detected in IDLE
//   and skip CALC. Results are the same either way.
//
// Ports:
//   clk          core clock
//   rst          synchronous active-high reset
//   start_i      EX holds a valid divide op (held until retire)
//   op_i         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend_i   rs1, divisor_i rs2 (sampled on IDLE->busy)
//   flush_i      annuls the EX instruction, cancels any op
//   stalled_i    stall vector; bit 4 = stage after EX frozen
//   stallreq_o   EX stall request
//   ready_o      result valid (DONE)
//   result_o     quotient/remainder, 0 when not ready
//
// state | meaning
// IDLE  | waiting for start_i
// CALC  | one restoring step per cycle, 32 steps
// FIX   | sign / special-case fixup, result registered
// DONE  | result valid, waiting for the stage after EX to advance
module ex_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  input  logic [4:0]  stalled_i,
  output logic        stallreq_o,
  output logic        ready_o,
  output logic [31:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;      // {rem, quo} shift register
  logic [31:0] dvsr;     // absolute divisor
  logic [31:0] a_raw;
  logic [31:0] b_raw;
  logic [31:0] res_q;
  logic [1:0]  op_q;
  logic        neg_q;
  logic        neg_r;

  // Operand conditioning on the raw inputs
  logic        in_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic        in_special;

  assign in_signed  = ~op_i[0];
  assign a_abs      = (in_signed & dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
  assign b_abs      = (in_signed & divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;
  assign in_special = (divisor_i == 32'd0) |
                      (in_signed & (dividend_i == 32'h8000_0000) & (divisor_i == 32'hFFFF_FFFF));

  // One restoring step. The remainder is always below the divisor, so after
  // the shift the 33-bit partial fits, and a non-negative difference fits in
  // 32 bits; the low 32 bits of the subtraction are therefore exact.
  logic [32:0] part;
  logic        no_borrow;
  logic [31:0] rem_next;

  assign part      = acc[63:31];
  assign no_borrow = (part >= {1'b0, dvsr});
  assign rem_next  = no_borrow ? (part[31:0] - dvsr) : part[31:0];

  // Fixup
  logic [31:0] q_raw;
  logic [31:0] r_raw;
  logic [31:0] quo_f;
  logic [31:0] rem_f;
  logic [31:0] fix_res;
  logic        q_signed;
  logic        div_zero;
  logic        ovf;

  assign q_raw    = acc[31:0];
  assign r_raw    = acc[63:32];
  assign q_signed = ~op_q[0];
  assign div_zero = (b_raw == 32'd0);
  assign ovf      = q_signed & (a_raw == 32'h8000_0000) & (b_raw == 32'hFFFF_FFFF);

  always_comb begin
    quo_f = neg_q ? (32'd0 - q_raw) : q_raw;
    rem_f = neg_r ? (32'd0 - r_raw) : r_raw;
    if (div_zero) begin
      quo_f = 32'hFFFF_FFFF;
      rem_f = a_raw;
    end else if (ovf) begin
      quo_f = 32'h8000_0000;
      rem_f = 32'd0;
    end
    fix_res = op_q[1] ? rem_f : quo_f;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 5'd0;
      acc   <= 64'd0;
      dvsr  <= 32'd0;
      a_raw <= 32'd0;
      b_raw <= 32'd0;
      op_q  <= 2'd0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= 32'd0;
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            acc   <= {32'd0, a_abs};
            dvsr  <= b_abs;
            a_raw <= dividend_i;
            b_raw <= divisor_i;
            op_q  <= op_i;
            neg_q <= in_signed & (dividend_i[31] ^ divisor_i[31]);
            neg_r <= in_signed & dividend_i[31];
            cnt   <= 5'd0;
`ifdef EX_DIV_FAST_SPECIAL_EN
            state <= in_special ? FIX : CALC;
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc <= {rem_next, acc[30:0], no_borrow};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          res_q <= fix_res;
          state <= DONE;
        end
        DONE: begin
          // start_i low here means EX abandoned the op; drop the result.
          if (!stalled_i[4] || !start_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef EX_DIV_FAST_SPECIAL_EN
  // Special cases take the full CALC path in this build.
  logic unused_special;
  assign unused_special = in_special;
`endif

  assign stallreq_o = ~flush_i & (((state == IDLE) & start_i) | (state == CALC) | (state == FIX));
  assign ready_o    = (state == DONE);
  assign result_o   = (state == DONE) ? res_q : 32'd0;

endmodule

// File: tb/tb_ex_div.sv
module tb_ex_div;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic        flush_i;
  logic [4:0]  stalled_i;
  logic        stallreq_o;
  logic        ready_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef EX_DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_DONE = 2;
`else
  localparam int SPECIAL_DONE = 34;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  ex_div dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .flush_i    (flush_i),
    .stalled_i  (stalled_i),
    .stallreq_o (stallreq_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an op in the current cycle (cycle 0) and runs until ready_o or
  // a 60-cycle budget expires. Leaves start_i high so the caller decides
  // how the op retires.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int stall_cnt, output logic [31:0] res);
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    start_i    = 1'b1;
    done_cyc   = 0;
    stall_cnt  = 0;
    #1;
    if (stallreq_o) stall_cnt++;
    while (!ready_o && done_cyc < 60) begin
      tick();
      done_cyc++;
      if (!ready_o && stallreq_o) stall_cnt++;
    end
    res = result_o;
  endtask

  task automatic retire();
    stalled_i = 5'b00000;
    tick();
    start_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({stallreq_o, ready_o, result_o} !== {1'b0, 1'b0, 32'd0})
      $display("FAIL reset: stallreq=%0b ready=%0b result=%h, want 0 0 0", stallreq_o, ready_o, result_o);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  // Runs one op, checks result, done cycle and stall length, then retires.
  task automatic test_vector(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int exp_done);
    int dc, sc;
    logic [31:0] r;
    do_op(op, a, b, dc, sc, r);
    n_checks++;
    if (r !== exp || dc != exp_done || sc != exp_done)
      $display("FAIL %s: result=%h done=%0d stall=%0d, want result=%h done=%0d stall=%0d",
               name, r, dc, sc, exp, exp_done, exp_done);
    else n_pass++;
    retire();
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 32'd0)
      $display("FAIL %s_retire: ready=%0b result=%h, want 0 0", name, ready_o, result_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    int dc, sc;
    logic [31:0] r;
    logic saw_ready;
    saw_ready = 1'b0;
    op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; start_i = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ready_o) saw_ready = 1'b1;
    end
    flush_i = 1'b1;
    #1;
    n_checks++;
    if (stallreq_o !== 1'b0)
      $display("FAIL flush_stallreq: stallreq=%0b, want 0", stallreq_o);
    else n_pass++;
    tick();
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    n_checks++;
    if (stallreq_o !== 1'b0 || ready_o !== 1'b0)
      $display("FAIL flush_cycle11: stallreq=%0b ready=%0b, want 0 0", stallreq_o, ready_o);
    else n_pass++;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ready_o) saw_ready = 1'b1;
    end
    n_checks++;
    if (saw_ready !== 1'b0)
      $display("FAIL flush_no_ready: ready seen=%0b, want 0", saw_ready);
    else n_pass++;
    do_op(OP_DIVU, 32'd9, 32'd3, dc, sc, r);
    n_checks++;
    if (r !== 32'd3 || dc != 34)
      $display("FAIL flush_after: result=%h done=%0d, want 3 34", r, dc);
    else n_pass++;
    retire();
  endtask

  // Immediate restart after flush: DUT must be IDLE right away.
  task automatic test_flush_restart();
    int dc, sc;
    logic [31:0] r;
    op_i = OP_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; start_i = 1'b1;
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    do_op(OP_DIVU, 32'd81, 32'd9, dc, sc, r);
    n_checks++;
    if (r !== 32'd9 || dc != 34 || sc != 34)
      $display("FAIL flush_restart: result=%h done=%0d stall=%0d, want 9 34 34", r, dc, sc);
    else n_pass++;
    retire();
  endtask

  task automatic test_stall_hold();
    int dc, sc;
    logic [31:0] r;
    logic bad;
    bad = 1'b0;
    stalled_i = 5'b11111;
    do_op(OP_DIVU, 32'd100, 32'd7, dc, sc, r);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (ready_o !== 1'b1 || result_o !== 32'd14 || stallreq_o !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad || r !== 32'd14 || dc != 34)
      $display("FAIL stall_hold: held_bad=%0b result=%h done=%0d, want 0 %h 34", bad, r, dc, 32'd14);
    else n_pass++;
    stalled_i = 5'b01111;
    tick();
    start_i = 1'b0;
    #1;
    n_checks++;
    if (ready_o !== 1'b0 || result_o !== 32'd0)
      $display("FAIL stall_release: ready=%0b result=%h, want 0 0", ready_o, result_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int dc, sc;
    logic [31:0] r;
    do_op(OP_DIVU, 32'd100, 32'd7, dc, sc, r);
    stalled_i = 5'b00000;
    tick();
    do_op(OP_REMU, 32'd100, 32'd7, dc, sc, r);
    n_checks++;
    if (r !== 32'd2 || dc != 34 || sc != 34)
      $display("FAIL back_to_back: result=%h done=%0d stall=%0d, want 2 34 34", r, dc, sc);
    else n_pass++;
    retire();
  endtask

  task automatic test_reset_midop();
    int dc, sc;
    logic [31:0] r;
    op_i = OP_DIVU; dividend_i = 32'd77; divisor_i = 32'd7; start_i = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    start_i = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (stallreq_o !== 1'b0 || ready_o !== 1'b0)
      $display("FAIL reset_midop: stallreq=%0b ready=%0b, want 0 0", stallreq_o, ready_o);
    else n_pass++;
    do_op(OP_DIVU, 32'd77, 32'd7, dc, sc, r);
    n_checks++;
    if (r !== 32'd11 || dc != 34)
      $display("FAIL reset_midop_after: result=%h done=%0d, want %h 34", r, dc, 32'd11);
    else n_pass++;
    retire();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; op_i = 2'b00; dividend_i = 32'd0; divisor_i = 32'd0;
    flush_i = 1'b0; stalled_i = 5'b00000;
    test_reset();
    test_vector("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 34);
    test_vector("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 34);
    test_vector("div_m7_2",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    test_vector("rem_m7_2",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    test_vector("rem_7_m2",   OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, 34);
    test_vector("div_7_m2",   OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    test_vector("div_m100_m7", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34);
    test_vector("rem_m100_m7", OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34);
    test_vector("div_5_0",    OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_DONE);
    test_vector("remu_5_0",   OP_REMU, 32'd5, 32'd0, 32'd5, SPECIAL_DONE);
    test_vector("rem_m5_0",   OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPECIAL_DONE);
    test_vector("divu_5_0",   OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPECIAL_DONE);
    test_vector("div_ovf",    OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPECIAL_DONE);
    test_vector("rem_ovf",    OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPECIAL_DONE);
    test_vector("divu_big",   OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    test_vector("remu_big",   OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    test_vector("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
    test_flush();
    test_flush_restart();
    test_stall_hold();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_div.md
# ex_div

Iterative 32-bit radix-2 divider for the EX stage, implementing RV32M DIV/DIVU/REM/REMU. It is a stall requester on the pipeline stall protocol. It drives the EX stall request while a division is in flight, and consumes the stall vector from the stall controller so it knows when EX may retire the result. It sits beside the ALU in `ex`, with its result muxed onto the EX write-back data.

## Interface
- No parameters; data width fixed at 32.
- `clk  input  1`  core clock; all state updates on rising edge.
- `rst  input  1`  reset, synchronous, active-high.
- `start_i  input  1`  EX holds a valid M-extension divide op; held high by EX until the op retires.
- `op_i  input  2`  `00` DIV, `01` DIVU, `10` REM, `11` REMU; sampled on the IDLE→busy transition.
- `dividend_i  input  32`  rs1 value; sampled on the IDLE→busy transition.
- `divisor_i  input  32`  rs2 value; sampled on the IDLE→busy transition.
- `flush_i  input  1`  EX instruction annulled (branch / trap); cancels any op.
- `stalled_i  input  5`  stall vector from the stall controller; bit 4 = the stage after EX is frozen.
- `stallreq_o  output  1`  EX stall request to the stall controller.
- `ready_o  output  1`  result valid (DONE state).
- `result_o  output  32`  quotient or remainder; 0 when not `ready_o`.

## Operation
- The FSM has four states: IDLE, CALC, FIX, DONE.
- IDLE:
  - If `start_i & ~flush_i`, latch the operands and op, and go to CALC.
  - Operands are latched as absolute values for signed ops; the raw values are kept for the special cases.
  - Latch `neg_q = a[31]^b[31]` and `neg_r = a[31]`. Both are 0 for unsigned ops.
  - Clear the 5-bit counter.
- CALC:
  - Each cycle does one restoring step on a 64-bit {rem, quo} shift register: shift left 1, subtract the divisor from the upper 33 bits, and keep the result if it is non-negative; the quotient bit is the no-borrow flag.
  - The counter increments each step. After step 32 (counter wraps 31→0), go to FIX.
- FIX: apply the sign and special-case fixups, register `result_o`, and go to DONE.
- DONE:
  - `ready_o=1`.
  - If `stalled_i[4]==0`, EX advances this cycle; go to IDLE.
  - Otherwise hold DONE with the result stable.
- Arithmetic rules:
  - Signed quotient = `neg_q ? -q : q`.
  - Signed remainder = `neg_r ? -r : r`.
  - Negation is two's complement, truncated to 32 bits.
- Divide by zero (divisor == 0): quotient = `32'hFFFFFFFF` and remainder = dividend, for both signed and unsigned ops. These values are forced, not derived from the sign rules.
- Signed overflow (dividend == `32'h80000000`, divisor == `32'hFFFFFFFF`, DIV/REM only): quotient = `32'h80000000`, remainder = 0.
- `stallreq_o = (IDLE & start_i & ~flush_i) | CALC | FIX`. It is combinational from state, so EX freezes in the same cycle the op is first seen.
- Flush:
  - `flush_i` in any state returns to IDLE on the next edge.
  - In IDLE, flush suppresses the start.
  - `stallreq_o` is forced 0 while `flush_i=1`.
  - No result is produced for a flushed op.
- Reset: state IDLE, counter 0, `stallreq_o=0`, `ready_o=0`, `result_o=0`. Reset mid-op abandons the op.

## Timing
- Cycle 0 is the first cycle `start_i=1` in IDLE.
- Without the fast-path macro:
  - CALC occupies cycles 1–32, FIX is cycle 33, and DONE is cycle 34.
  - `stallreq_o` is high for cycles 0–33.
  - `ready_o` first goes high at cycle 34.
- Back-to-back divides: the next op's cycle 0 is the cycle after DONE exits. There is no IDLE bubble beyond the required one cycle.
- If `start_i` drops without a flush during CALC or FIX (protocol violation), the unit finishes the op and discards the result in DONE.

## Configuration
- `EX_DIV_FAST_SPECIAL_EN`
  - Defined: in IDLE, divide-by-zero and signed overflow are detected on the raw inputs, and the unit goes straight to FIX, skipping CALC. DONE is reached at cycle 2 and `stallreq_o` is high for cycles 0–1.
  - Undefined: the special cases run the full 32 CALC steps (DONE at cycle 34), and the override is applied in FIX.
  - Results are bit-identical either way.

## Test plan
- DIVU 100/7 → DONE at cycle 34, `result_o=14`; REMU 100/7 → 2; `stallreq_o` high for exactly 34 cycles.
- DIV −7/2 → `32'hFFFFFFFD` (−3); REM −7/2 → `32'hFFFFFFFF` (−1); REM 7/−2 → 1.
- DIV 5/0 → `32'hFFFFFFFF`, REMU 5/0 → 5. With `EX_DIV_FAST_SPECIAL_EN`: DONE at cycle 2. Without it: DONE at cycle 34.
- DIV `32'h80000000`/`32'hFFFFFFFF` → `32'h80000000`; REM same operands → 0.
- Start DIVU, assert `flush_i` at cycle 10:
  - Expect IDLE at cycle 11, `stallreq_o=0` from cycle 10, and `ready_o` never high.
  - A following DIVU 9/3 returns 3.
- Hold `stalled_i=5'b11111` for 4 cycles after DONE: `ready_o` and `result_o` stay stable and `stallreq_o=0`; IDLE follows on the cycle after `stalled_i[4]` drops.
